ram_data_arbiter: RTL and testbench

- Shares the single data port of the dual-port instruction/data RAM between two requesters: master 0 (LSU) and master 1 (debug/loader DMA engine).
- Selects one request per cycle and drives the RAM data port combinationally from the winner.
- Returns read data through a registered response stage, tagged to the granted master.
- Sits between the core/debug logic and the RAM data port. The instruction-fetch port is untouched.

---
 rtl/ram_data_arbiter_pkg.sv | 15 +
 rtl/ram_data_arbiter_rr_arb2.sv | 68 ++++++
 rtl/ram_data_arbiter.sv | 106 ++++++++++
 tb/tb_ram_data_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_data_arbiter_pkg.sv
// Shared constants for the RAM data-port arbiter.
package ram_data_arbiter_pkg;

  // Arbitration modes
  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Master index width (two masters)
  localparam int MIDX_W = 1;

  // Hold counter width and its saturation value
  localparam int HOLD_W   = 4;
  localparam int HOLD_SAT = 15;

endpackage

// File: rtl/ram_data_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin with a bounded hold, or fixed priority to master 0.
//
// state        | meaning
// last_winner  | master granted most recently (1 after reset, so master 0 goes first)
// hold         | consecutive grants to last_winner; 0 after an idle cycle or reset
module ram_data_arbiter_rr_arb2
  import ram_data_arbiter_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR,
  parameter int MAX_HOLD = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT_C = HOLD_W'(HOLD_SAT);

  logic [MIDX_W-1:0] last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [MIDX_W-1:0] win;
  logic              any;
  logic              keep;

  // Pick the winner and work out the next arbitration state
  always_comb begin
    any    = (|req_i) & ~rst_i;
    // last_winner may stay only while it is on a live streak below the limit
    keep   = (hold_q != '0) && (hold_q < MAX_HOLD_C);
    win    = '0;
    gnt_o  = '0;
    last_d = last_q;
    hold_d = hold_q;

    if (req_i == 2'b10) begin
      win = 1'b1;
    end else if (req_i == 2'b11) begin
      if (ARB_MODE == ARB_FIXED) win = 1'b0;
      else                       win = keep ? last_q : ~last_q;
    end

    if (any) begin
      gnt_o[win] = 1'b1;
      if (win == last_q) begin
        if (hold_q != HOLD_SAT_C) hold_d = hold_q + 4'd1;
      end else begin
        last_d = win;
        hold_d = 4'd1;
      end
    end else begin
      hold_d = '0;
    end
  end

  // Arbitration state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
      hold_q <= '0;
    end else begin
      last_q <= last_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/ram_data_arbiter.sv
// Shares the RAM data port between the LSU (m0) and the debug/loader DMA (m1).
module ram_data_arbiter
  import ram_data_arbiter_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR,
  parameter int MAX_HOLD = 4,
  parameter int AW       = 32,
  parameter int DW       = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic          ram_ce_o,
  output logic          ram_we_o,
  output logic [3:0]    ram_sel_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wdata_o,
  input  logic [DW-1:0] ram_rdata_i
);

  logic [1:0]    gnt;
  logic          m0_rvalid_q, m0_rvalid_d;
  logic          m1_rvalid_q, m1_rvalid_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;

  ram_data_arbiter_rr_arb2 #(
    .ARB_MODE (ARB_MODE),
    .MAX_HOLD (MAX_HOLD)
  ) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i ({m1_req_i, m0_req_i}),
    .gnt_o (gnt)
  );

  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];

  // Drive the RAM data port from the winner; idle port is all zeros
  always_comb begin
    ram_ce_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_sel_o   = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (gnt[0]) begin
      ram_ce_o    = 1'b1;
      ram_we_o    = m0_we_i;
      ram_sel_o   = m0_sel_i;
      ram_addr_o  = m0_addr_i;
      ram_wdata_o = m0_wdata_i;
    end else if (gnt[1]) begin
      ram_ce_o    = 1'b1;
      ram_we_o    = m1_we_i;
      ram_sel_o   = m1_sel_i;
      ram_addr_o  = m1_addr_i;
      ram_wdata_o = m1_wdata_i;
    end
  end

  // Read responses: capture RAM data for a granted read, hold it otherwise
  always_comb begin
    m0_rvalid_d = gnt[0] & ~m0_we_i;
    m1_rvalid_d = gnt[1] & ~m1_we_i;
    m0_rdata_d  = m0_rvalid_d ? ram_rdata_i : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? ram_rdata_i : m1_rdata_q;
  end

  // Response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  // A response still in flight when reset arrives is dropped immediately
  assign m0_rvalid_o = m0_rvalid_q & ~rst_i;
  assign m1_rvalid_o = m1_rvalid_q & ~rst_i;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;

endmodule

// File: tb/tb_ram_data_arbiter.sv
// Bench for ram_data_arbiter: three configurations on shared stimulus, a
// behavioural arbitration/memory model and directed literal checks.
module tb_ram_data_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [3:0]  m0_sel = 0, m1_sel = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;

  // main instance: round-robin, MAX_HOLD = 4, connected to the bench RAM
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ce, ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  // alternate instances: grants only are of interest
  logic        h1_g0, h1_g1, h1_v0, h1_v1, h1_ce, h1_we;
  logic [31:0] h1_d0, h1_d1, h1_addr, h1_wd;
  logic [3:0]  h1_sel;
  logic        fx_g0, fx_g1, fx_v0, fx_v1, fx_ce, fx_we;
  logic [31:0] fx_d0, fx_d1, fx_addr, fx_wd;
  logic [3:0]  fx_sel;
  logic [31:0] zero_rdata = 32'h0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_data_arbiter #(.ARB_MODE(0), .MAX_HOLD(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_sel_i(m0_sel), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_sel_i(m1_sel), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_sel_o(ram_sel), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata));

  ram_data_arbiter #(.ARB_MODE(0), .MAX_HOLD(1)) dut_h1 (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_sel_i(m0_sel), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(h1_g0), .m0_rvalid_o(h1_v0), .m0_rdata_o(h1_d0),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_sel_i(m1_sel), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(h1_g1), .m1_rvalid_o(h1_v1), .m1_rdata_o(h1_d1),
    .ram_ce_o(h1_ce), .ram_we_o(h1_we), .ram_sel_o(h1_sel), .ram_addr_o(h1_addr),
    .ram_wdata_o(h1_wd), .ram_rdata_i(zero_rdata));

  ram_data_arbiter #(.ARB_MODE(1), .MAX_HOLD(4)) dut_fx (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_sel_i(m0_sel), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(fx_g0), .m0_rvalid_o(fx_v0), .m0_rdata_o(fx_d0),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_sel_i(m1_sel), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(fx_g1), .m1_rvalid_o(fx_v1), .m1_rdata_o(fx_d1),
    .ram_ce_o(fx_ce), .ram_we_o(fx_we), .ram_sel_o(fx_sel), .ram_addr_o(fx_addr),
    .ram_wdata_o(fx_wd), .ram_rdata_i(zero_rdata));

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Bench RAM: combinational read, write at the clock edge
  assign ram_rdata = mem[ram_addr[9:2]];
  always @(posedge clk) if (ram_ce && ram_we) mem[ram_addr[9:2]] <= merge(mem[ram_addr[9:2]], ram_wdata, ram_sel);

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // per configuration: 0 = main (rr,4), 1 = h1 (rr,1), 2 = fx (fixed)
  int cfg_mode [3] = '{0, 0, 1};
  int cfg_hold [3] = '{4, 1, 4};
  int last_w   [3];
  int streak   [3];
  bit          exp_v0, exp_v1;
  logic [31:0] exp_d0, exp_d1;
  bit          mdl_g0, mdl_g1;

  function automatic int pick(int k, bit r0, bit r1);
    if (!r0 && !r1) return -1;
    if (r0 && !r1)  return 0;
    if (!r0 && r1)  return 1;
    if (cfg_mode[k] == 1) return 0;
    if (streak[k] > 0 && streak[k] < cfg_hold[k]) return last_w[k];
    return 1 - last_w[k];
  endfunction

  function automatic logic [1:0] onehot(int w);
    if (w < 0) return 2'b00;
    return (w == 0) ? 2'b01 : 2'b10;
  endfunction

  // Compare every cycle, then advance the model as the coming edge will
  always @(negedge clk) begin
    int w [3];
    for (int k = 0; k < 3; k++) w[k] = rst ? -1 : pick(k, m0_req, m1_req);
    chk("gnt_main", {30'b0, m1_gnt, m0_gnt}, {30'b0, onehot(w[0])});
    chk("gnt_hold1", {30'b0, h1_g1, h1_g0}, {30'b0, onehot(w[1])});
    chk("gnt_fixed", {30'b0, fx_g1, fx_g0}, {30'b0, onehot(w[2])});
    mdl_g0 = (w[0] == 0);
    mdl_g1 = (w[0] == 1);
    begin
      logic        e_ce, e_we;
      logic [3:0]  e_sel;
      logic [31:0] e_addr, e_wd;
      e_ce = 0; e_we = 0; e_sel = 0; e_addr = 0; e_wd = 0;
      if (w[0] == 0) begin e_ce = 1; e_we = m0_we; e_sel = m0_sel; e_addr = m0_addr; e_wd = m0_wdata; end
      if (w[0] == 1) begin e_ce = 1; e_we = m1_we; e_sel = m1_sel; e_addr = m1_addr; e_wd = m1_wdata; end
      chk("ram_ctl", {26'b0, e_ce, e_we, e_sel}, {26'b0, ram_ce, ram_we, ram_sel});
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_wdata", ram_wdata, e_wd);
      chk("rvalid", {30'b0, m1_rvalid, m0_rvalid}, {30'b0, exp_v1 & ~rst, exp_v0 & ~rst});
      chk("rdata0", m0_rdata, exp_d0);
      chk("rdata1", m1_rdata, exp_d1);
      if (rst) begin
        for (int k = 0; k < 3; k++) begin last_w[k] = 1; streak[k] = 0; end
        exp_v0 = 0; exp_v1 = 0; exp_d0 = 0; exp_d1 = 0;
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (w[k] < 0) streak[k] = 0;
          else if (w[k] == last_w[k]) streak[k] = (streak[k] < 15) ? streak[k] + 1 : 15;
          else begin last_w[k] = w[k]; streak[k] = 1; end
        end
        exp_v0 = (w[0] == 0) && !m0_we;
        exp_v1 = (w[0] == 1) && !m1_we;
        if (exp_v0) exp_d0 = ref_mem[m0_addr[9:2]];
        if (exp_v1) exp_d1 = ref_mem[m1_addr[9:2]];
        if (e_ce && e_we) ref_mem[e_addr[9:2]] = merge(ref_mem[e_addr[9:2]], e_wd, e_sel);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_sel = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_sel = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle(); tick(); tick(); rst = 0;
  endtask

  task automatic m0_rd(logic [31:0] a);
    m0_req = 1; m0_we = 0; m0_sel = 4'hF; m0_addr = a;
  endtask

  task automatic m1_rd(logic [31:0] a);
    m1_req = 1; m1_we = 0; m1_sel = 4'hF; m1_addr = a;
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 256; i++) begin v = $urandom; mem[i] = v; ref_mem[i] = v; end
    mem[64] = 32'hDEADBEEF; ref_mem[64] = 32'hDEADBEEF;
    mem[16] = 32'hAABBCCDD; ref_mem[16] = 32'hAABBCCDD;
    for (int k = 0; k < 3; k++) begin last_w[k] = 1; streak[k] = 0; end
    exp_v0 = 0; exp_v1 = 0; exp_d0 = 0; exp_d1 = 0;

    do_reset();
    @(negedge clk);
    chk("rst_state", {28'b0, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid}, 32'h0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);

    // m0 read of 0x100
    tick(); m0_rd(32'h100);
    @(negedge clk);
    chk("t1_gnt", {30'b0, m1_gnt, m0_gnt}, 32'h1);
    chk("t1_addr", ram_addr, 32'h100);
    tick(); idle();
    @(negedge clk);
    chk("t1_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'h1);
    chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t1_m1_rdata", m1_rdata, 32'h0);

    // both requesting continuously from reset
    tick(); do_reset(); m0_rd(32'h10); m1_rd(32'h20);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("alt_h1", {30'b0, h1_g1, h1_g0}, (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("fixed_m0", {30'b0, fx_g1, fx_g0}, 32'h1);
      chk("hold4_main", {30'b0, m1_gnt, m0_gnt}, ((i / 4) % 2 == 0) ? 32'h1 : 32'h2);
      tick();
    end

    // m1 alone for one cycle, then both
    idle(); do_reset(); m1_rd(32'h30);
    @(negedge clk);
    chk("m1_alone", {30'b0, m1_gnt, m0_gnt}, 32'h2);
    tick(); m0_rd(32'h34);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold4_m1", {30'b0, m1_gnt, m0_gnt}, (i < 3) ? 32'h2 : 32'h1);
      tick();
    end

    // m1 partial write then m0 read back
    idle(); do_reset();
    m1_req = 1; m1_we = 1; m1_sel = 4'b0011; m1_addr = 32'h40; m1_wdata = 32'h12345678;
    @(negedge clk);
    chk("wr_gnt", {26'b0, m1_gnt, m0_gnt, ram_we, ram_ce, 2'b0}, {26'b0, 2'b10, 2'b11, 2'b0});
    chk("wr_sel", {28'b0, ram_sel}, 32'h3);
    tick(); idle(); m0_rd(32'h40);
    @(negedge clk);
    chk("wr_no_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'h0);
    tick(); idle();
    @(negedge clk);
    chk("rb_rvalid", {31'b0, m0_rvalid}, 32'h1);
    chk("rb_rdata", m0_rdata, 32'hAABB5678);

    // reset while a read response is pending
    tick(); m0_rd(32'h100);
    @(negedge clk);
    chk("pend_gnt", {31'b0, m0_gnt}, 32'h1);
    tick(); idle(); rst = 1;
    @(negedge clk);
    chk("pend_rvalid_in_rst", {31'b0, m0_rvalid}, 32'h0);
    tick(); rst = 0;
    @(negedge clk);
    chk("pend_rvalid_after", {31'b0, m0_rvalid}, 32'h0);
    chk("pend_rdata_after", m0_rdata, 32'h0);
    tick(); m0_rd(32'h8); m1_rd(32'hC);
    @(negedge clk);
    chk("post_rst_first", {30'b0, m1_gnt, m0_gnt}, 32'h1);
    tick();

    // randomized traffic; a master keeps its request until granted, occasionally drops it
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!(m0_req && !mdl_g0 && $urandom_range(0, 7) != 0)) begin
        m0_req = ($urandom_range(0, 2) != 0); m0_we = $urandom_range(0, 1);
        m0_sel = 4'($urandom); m0_addr = {22'b0, 8'($urandom), 2'b00}; m0_wdata = $urandom;
      end
      if (!(m1_req && !mdl_g1 && $urandom_range(0, 7) != 0)) begin
        m1_req = ($urandom_range(0, 2) != 0); m1_we = $urandom_range(0, 1);
        m1_sel = 4'($urandom); m1_addr = {22'b0, 8'($urandom), 2'b00}; m1_wdata = $urandom;
      end
      tick();
    end
    rst = 0; idle();
    tick(); tick();
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
